flash_burst_reader: RTL and testbench
=====================================

# flash_burst_reader

Avalon-MM burst-read master that drives the flash loader's `avl_mem` slave port. It copies a block of 32-bit words from serial flash into a valid/ready stream, for example GPU sprite or palette RAM fill logic. It runs credit-based flow control, so it never requests more words than its internal FIFO can absorb. Software, or the GPU boot sequencer, supplies the start word address and word count, then waits for `done`.

## Interface
- `DEPTH`, default 128: FIFO depth in words. Must be a power of 2 and ≥ `BURST_MAX`.
- `BURST_MAX`, default 64: maximum `avm_burstcount`. Must be ≤ 64, since `avm_burstcount` is 7 bits.
- `clk_clk` in 1: single clock for the whole block.
- `reset_reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle command strobe. Ignored while `busy`=1.
- `src_addr` in 21: start word address. Sampled when `start` is accepted.
- `word_count` in 16: number of words to read, 0..65535. Sampled with `start`.
- `busy` out 1: high from start acceptance until the `done` cycle.
- `done` out 1: one-cycle pulse when the transfer is complete.
- `avm_read` out 1: read request.
- `avm_address` out 21: word address of the burst.
- `avm_burstcount` out 7: words in the burst.
- `avm_byteenable` out 4: constant 4'hF.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 32: returned read data.
- `avm_readdatavalid` in 1: return data strobe.
- `out_data` out 32: stream data.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: sink ready. A word transfers when `out_valid` and `out_ready` are both high.

## Operation
- **States:** IDLE, REQ, DRAIN, DONE.
- **IDLE:**
  - `start` with `word_count`≠0 → latch `addr`=`src_addr` and `remaining`=`word_count`, go to REQ.
  - `start` with `word_count`=0 → go directly to DONE. No bus activity.
- **Credit accounting:**
  - `pending` = words accepted on the bus but not yet returned.
  - `free` = `DEPTH` − `fifo_count` − `pending`.
  - `len` = min(`BURST_MAX`, `remaining`).
- **REQ:**
  - If `free` ≥ `len` and no request is outstanding on the bus, drive `avm_read`=1, `avm_address`=`addr`, `avm_burstcount`=`len`.
  - On acceptance (`avm_read` & !`avm_waitrequest`):
    - `addr` += `len`, modulo 2^21; wraps 0x1FFFFF→0.
    - `remaining` −= `len`.
    - `pending` += `len`.
  - When `remaining` reaches 0 → go to DRAIN.
- **DRAIN:** wait until `pending`=0 and the FIFO is empty, i.e. the last word has been popped, then go to DONE.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- **Return data:**
  - Every `avm_readdatavalid` word is written to the FIFO unconditionally; the credit scheme guarantees space.
  - `pending` −= 1 per `avm_readdatavalid`.
  - Acceptance and readdatavalid in the same cycle → net `pending` change is +`len`−1.
- **FIFO:**
  - First-word-fall-through: `out_valid` = not empty, `out_data` = head entry.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - A push to a full FIFO, or a readdatavalid while `pending`=0, is a protocol violation and is flagged by bench assertions.
- **Counter widths:** `pending` and `fifo_count` are clog2(`DEPTH`+1) bits and never exceed `DEPTH`. `remaining` is 16 bits.

## Timing
- **Reset values** (all outputs, asynchronous, while `reset_reset_n`=0): `busy`=0, `done`=0, `avm_read`=0, `avm_address`=0, `avm_burstcount`=0, `out_valid`=0, `out_data`=0.
- **Reset mid-transfer:**
  - FIFO, `pending`, `remaining` and state clear immediately.
  - Words returned by the slave after reset release are discarded, because state is IDLE and `pending`=0. The system must reset the flash loader together with this block.
- **Latency:**
  - `start` at edge N → `busy`=1 after N. The first `avm_read` is at cycle N+1 at the earliest.
  - readdatavalid sampled at edge M → word visible with `out_valid`=1 after M.
- **Waitrequest:** while `avm_read`=1 and `avm_waitrequest`=1, `avm_read`, `avm_address` and `avm_burstcount` hold stable.
- **Back-to-back bursts:** the next burst may be asserted in the cycle after acceptance if credits allow. The master does not wait for the prior burst's data.
- **Done timing:**
  - `done` rises the cycle after the final pop, or the cycle after `start` when `word_count`=0.
  - `start` asserted in the `done` cycle is ignored.

## Test plan
- **Zero count:** `start`, `word_count`=0 → `done` pulses 1 cycle after `start`; `avm_read` never asserts; `busy` stays 0 throughout.
- **Single short burst:** `src_addr`=0x000100, `word_count`=5, `out_ready`=1 → one burst at 0x100 with burstcount 5; stream outputs D0..D4 in order; `done` the cycle after the D4 pop.
- **Burst splitting:** `word_count`=150, `out_ready`=1 → bursts (0x000000, 64), (0x000040, 64), (0x000080, 22); 150 words out; `done` once.
- **Backpressure credits:** `word_count`=200, `out_ready`=0 → exactly two 64-word bursts issued, then `avm_read` stays 0. Raising `out_ready` → third burst asserted only once 64 slots are freed.
- **Waitrequest stall:** `avm_waitrequest` held 10 cycles on the first burst → `avm_address`/`avm_burstcount` unchanged across the stall; data intact.
- **Wrap and reset:**
  - `src_addr`=0x1FFFC0, `word_count`=128 → bursts at 0x1FFFC0 then 0x000000.
  - Repeat with `reset_reset_n` pulsed mid-burst → all outputs 0 immediately; a new `start` completes normally.

Source files
------------

// File: rtl/flash_burst_reader.sv
// Avalon-MM burst-read master that streams flash words into a first-word-fall-through FIFO.
// Bursts are only issued when the FIFO plus in-flight words leave room for the whole burst.
module flash_burst_reader #(
  parameter  int unsigned DEPTH     = 128,
  parameter  int unsigned BURST_MAX = 64,
  localparam int unsigned ADDR_W    = 21,
  localparam int unsigned CNT_W     = 16,
  localparam int unsigned BC_W      = 7,
  localparam int unsigned BE_W      = 4,
  localparam int unsigned DATA_W    = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              avm_read,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BC_W-1:0]   avm_burstcount,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned   CW          = $clog2(DEPTH + 1);
  localparam int unsigned   AW          = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [CW-1:0]       pending_q, pending_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       free_d;
  logic [BC_W-1:0]     len_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                avm_read_q, avm_read_d;
  logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic [BC_W-1:0]     avm_burstcount_q, avm_burstcount_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                accept;
  logic                push;
  logic                pop;
  logic                mem_empty;
  logic                mem_we;

  // FIFO: out_data_q is the head slot, mem_q holds everything behind it.
  always_comb begin
    push        = avm_readdatavalid && (pending_q != '0);
    pop         = out_valid_q && out_ready;
    mem_empty   = (wr_ptr_q == rd_ptr_q);
    mem_we      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (pop) begin
      if (!mem_empty) begin
        out_data_d = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + AW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (push) begin
      if (!out_valid_q || (pop && mem_empty)) begin
        out_data_d  = avm_readdata;
        out_valid_d = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Control FSM; issue decisions use post-edge counts so bursts can go back to back.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    remaining_d      = remaining_q;
    avm_read_d       = avm_read_q;
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    accept           = avm_read_q && !avm_waitrequest;

    if (accept) begin
      addr_d      = addr_q + ADDR_W'(avm_burstcount_q);
      remaining_d = remaining_q - CNT_W'(avm_burstcount_q);
      avm_read_d  = 1'b0;
    end
    pending_d = pending_q + (accept ? CW'(avm_burstcount_q) : CW'(0)) - CW'(push);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d      = src_addr;
            remaining_d = word_count;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (remaining_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((pending_d == '0) && (count_d == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    len_d  = (remaining_d >= BURST_MAX_C) ? BC_W'(BURST_MAX) : BC_W'(remaining_d);
    free_d = DEPTH_C - count_d - pending_d;

    if ((state_q == S_REQ) && (state_d == S_REQ) && !avm_read_d &&
        (32'(free_d) >= 32'(len_d))) begin
      avm_read_d       = 1'b1;
      avm_address_d    = addr_d;
      avm_burstcount_d = len_d;
    end

    busy_d = (state_d == S_REQ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      remaining_q      <= '0;
      pending_q        <= '0;
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      avm_read_q       <= 1'b0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      remaining_q      <= remaining_d;
      pending_q        <= pending_d;
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      avm_read_q       <= avm_read_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
    end
  end

  // Storage behind the head slot carries no reset.
  always_ff @(posedge clk_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= avm_readdata;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_read       = avm_read_q;
  assign avm_address    = avm_address_q;
  assign avm_burstcount = avm_burstcount_q;
  assign avm_byteenable = 4'hF;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

endmodule

// File: tb/tb_flash_burst_reader.sv
// Bench for flash_burst_reader: table of transfers, hand-written corner sequences and random
// transfers, all checked against a queue-based model of the slave, the FIFO and the stream.
module tb_flash_burst_reader;

  localparam int unsigned DEPTH     = 128;
  localparam int unsigned BURST_MAX = 64;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        start;
  logic [20:0] src_addr;
  logic [15:0] word_count;
  logic        busy, done, avm_read;
  logic [20:0] avm_address;
  logic [6:0]  avm_burstcount;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  flash_burst_reader #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .start(start), .src_addr(src_addr), .word_count(word_count),
    .busy(busy), .done(done),
    .avm_read(avm_read), .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [20:0] src;
    logic [15:0] cnt;
    int          rp;
    int          wp;
    int          nb;
    int          last_len;
  } vec_t;

  vec_t vecs [7];

  int n_cmp = 0;
  int n_bad = 0;

  int          rdy_pct, wait_pct, rdv_pct, wait_first;
  bit          start_req;
  logic [20:0] req_addr;
  logic [15:0] req_cnt;

  logic [20:0] slv_q [$];
  logic [20:0] exp_baddr [$];
  int          exp_blen [$];
  logic [31:0] exp_words [$];
  int          occ, nbursts, last_bc;
  bit          active, done_due, prev_stall, prev_busy;
  logic [20:0] prev_addr;
  logic [6:0]  prev_bc;

  function automatic logic [31:0] dword(input logic [20:0] a);
    return {11'h2AB, a};
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    chk(done == 1'b0, {tag, "_done"}, done, 0);
    chk(avm_read == 1'b0, {tag, "_avm_read"}, avm_read, 0);
    chk(avm_address == '0, {tag, "_avm_address"}, avm_address, 0);
    chk(avm_burstcount == '0, {tag, "_avm_burstcount"}, avm_burstcount, 0);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
    chk(out_data == '0, {tag, "_out_data"}, out_data, 0);
  endtask

  task automatic clear_model();
    slv_q.delete(); exp_baddr.delete(); exp_blen.delete(); exp_words.delete();
    occ = 0; active = 0; done_due = 0; prev_stall = 0; prev_busy = 0; wait_first = 0;
    start_req = 0;
  endtask

  // Expected bursts and words for one accepted command.
  task automatic accept_start();
    logic [20:0] a;
    int          rem, l;
    a = req_addr; rem = int'(req_cnt); nbursts = 0; last_bc = 0;
    if (rem == 0) done_due = 1; else active = 1;
    while (rem > 0) begin
      l = (rem > int'(BURST_MAX)) ? int'(BURST_MAX) : rem;
      exp_baddr.push_back(a);
      exp_blen.push_back(l);
      for (int i = 0; i < l; i++) exp_words.push_back(dword(a + 21'(i)));
      a   = a + 21'(l);
      rem = rem - l;
    end
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step();
    bit          in_done, acc, rdy, wr;
    logic [20:0] a;
    int          l;
    logic [31:0] w;
    @(negedge clk_clk);
    in_done = done_due;
    chk(done == done_due, "done", done, done_due);
    chk(busy == active, "busy", busy, active);
    chk(out_valid == (occ != 0), "out_valid", out_valid, occ != 0);
    if (prev_stall)
      chk(avm_read && avm_address == prev_addr && avm_burstcount == prev_bc, "stall_hold",
          {avm_read, avm_address, avm_burstcount}, {1'b1, prev_addr, prev_bc});
    if (avm_read)
      chk(occ + slv_q.size() + int'(avm_burstcount) <= int'(DEPTH), "credit",
          occ + slv_q.size() + int'(avm_burstcount), DEPTH);
    if (busy && !prev_busy) chk(!avm_read, "first_read_latency", avm_read, 0);
    prev_busy = busy;
    done_due  = 0;

    rdy = ($urandom_range(99) < rdy_pct);
    out_ready = rdy;
    if (avm_read && wait_first > 0) begin
      wr = 1; wait_first--;
    end else begin
      wr = ($urandom_range(99) < wait_pct);
    end
    avm_waitrequest = wr;

    if (slv_q.size() > 0 && $urandom_range(99) < rdv_pct) begin
      chk(occ < int'(DEPTH), "fifo_overflow", occ, DEPTH - 1);
      avm_readdatavalid = 1'b1;
      avm_readdata      = dword(slv_q.pop_front());
      occ++;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
    end

    acc = avm_read && !wr;
    if (acc) begin
      chk(exp_baddr.size() != 0, "extra_burst", avm_address, exp_baddr.size());
      if (exp_baddr.size() != 0) begin
        a = exp_baddr.pop_front();
        l = exp_blen.pop_front();
        chk(avm_address == a && avm_burstcount == 7'(l), "burst",
            {avm_address, avm_burstcount}, {a, 7'(l)});
      end
      for (int i = 0; i < int'(avm_burstcount); i++) slv_q.push_back(avm_address + 21'(i));
      nbursts++;
      last_bc = int'(avm_burstcount);
    end

    if (out_valid && rdy) begin
      chk(exp_words.size() != 0, "extra_word", out_data, exp_words.size());
      if (exp_words.size() != 0) begin
        w = exp_words.pop_front();
        chk(out_data == w, "out_data", out_data, w);
      end
      occ--;
      if (active && exp_words.size() == 0) begin
        active   = 0;
        done_due = 1;
      end
    end

    if (start_req) begin
      start = 1'b1; src_addr = req_addr; word_count = req_cnt; start_req = 0;
      if (!active && !in_done) accept_start();
    end else begin
      start = 1'b0; src_addr = 21'($urandom); word_count = 16'($urandom);
    end

    prev_stall = avm_read && wr;
    prev_addr  = avm_address;
    prev_bc    = avm_burstcount;
  endtask

  task automatic finish_xfer();
    int cyc = 0;
    while ((active || done_due) && cyc < 20000) begin
      step();
      cyc++;
    end
    chk(cyc < 20000, "xfer_timeout", cyc, 20000);
    chk(exp_words.size() == 0 && exp_baddr.size() == 0, "xfer_leftover",
        exp_words.size() + exp_baddr.size(), 0);
  endtask

  task automatic run_xfer(input logic [20:0] a, input logic [15:0] n, input int rp, input int wp);
    rdy_pct = rp; wait_pct = wp; req_addr = a; req_cnt = n; start_req = 1;
    step();
    finish_xfer();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_reset_n = 1'b0; start = 1'b0; src_addr = '0; word_count = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; out_ready = 1'b0;
    rdy_pct = 100; wait_pct = 0; rdv_pct = 70; req_addr = '0; req_cnt = '0;
    nbursts = 0; last_bc = 0;
    clear_model();

    vecs[0] = '{21'h000100, 16'd5,   100, 0,  1, 5};
    vecs[1] = '{21'h000000, 16'd150, 100, 0,  3, 22};
    vecs[2] = '{21'h1FFFC0, 16'd128, 100, 0,  2, 64};
    vecs[3] = '{21'h000777, 16'd0,   100, 0,  0, 0};
    vecs[4] = '{21'h1FFF00, 16'd300, 50,  30, 5, 44};
    vecs[5] = '{21'h012345, 16'd1,   70,  50, 1, 1};
    vecs[6] = '{21'h000055, 16'd65,  30,  20, 2, 1};

    #12;
    check_reset_outputs("por");
    chk(avm_byteenable == 4'hF, "byteenable", avm_byteenable, 4'hF);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 7; i++) begin
      run_xfer(vecs[i].src, vecs[i].cnt, vecs[i].rp, vecs[i].wp);
      chk(nbursts == vecs[i].nb, "nbursts", nbursts, vecs[i].nb);
      chk(last_bc == vecs[i].last_len, "last_len", last_bc, vecs[i].last_len);
      repeat (3) step();
    end

    // Sink stalled: credits allow exactly two full bursts, then the bus goes quiet.
    rdy_pct = 0; wait_pct = 0; req_addr = 21'h002000; req_cnt = 16'd200; start_req = 1;
    repeat (300) step();
    chk(nbursts == 2, "credit_bursts", nbursts, 2);
    chk(!avm_read, "credit_read_idle", avm_read, 0);
    rdy_pct = 100;
    finish_xfer();
    chk(nbursts == 4, "credit_total_bursts", nbursts, 4);
    repeat (2) step();

    // First burst stalled for ten cycles.
    wait_first = 10;
    run_xfer(21'h0ABCD0, 16'd20, 100, 0);
    chk(wait_first == 0, "stall_applied", wait_first, 0);
    chk(nbursts == 1, "stall_bursts", nbursts, 1);
    repeat (2) step();

    // Start in the done cycle is dropped.
    rdy_pct = 100; wait_pct = 0; req_addr = 21'h000300; req_cnt = 16'd3; start_req = 1;
    step();
    for (int c = 0; c < 2000 && active; c++) step();
    chk(done_due, "done_pending", done_due, 1);
    req_addr = 21'h000400; req_cnt = 16'd7; start_req = 1;
    step();
    repeat (8) step();
    chk(nbursts == 1, "start_in_done_ignored", nbursts, 1);

    // Reset in the middle of a wrapping transfer, then a clean rerun.
    rdy_pct = 50; wait_pct = 20; req_addr = 21'h1FFFC0; req_cnt = 16'd128; start_req = 1;
    step();
    repeat (30) step();
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    start = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) step();
    run_xfer(21'h1FFFC0, 16'd128, 100, 10);
    chk(nbursts == 2, "post_reset_bursts", nbursts, 2);
    repeat (2) step();

    for (int k = 0; k < 6; k++) begin
      logic [15:0] n;
      n = (k == 2) ? 16'd0 : 16'($urandom_range(1, 300));
      run_xfer(21'($urandom), n, int'($urandom_range(25, 100)), int'($urandom_range(0, 60)));
      repeat (2) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
